// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Central hazard controller for the five-stage MIPS pipeline.
//
// Every cycle it decides:
//   * whether the instruction in D must stall (data hazard or, optionally,
//     a HI/LO consumer waiting on the mult/div unit),
//   * which pipeline registers are cleared (IF/ID, ID/EX, EX/MEM control),
//   * which forwarding source each operand mux in D, E and M selects.
//
// It also owns the mult/div busy counter so that HI/LO consumers are held
// in D until the multi-cycle result is ready.
//
// Build option:
//   HAZARD_MD_EN  defined   -> mult/div counter, md_busy and MD stall built.
//                 undefined -> md_busy tied 0; mdUseD, md_startE and
//                              md_isdivE are ignored.
//
// Parameters:
//   MULT_CYC   busy cycles after a mult/multu issues (1..15)
//   DIV_CYC    busy cycles after a div/divu issues   (1..15)
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   A1D, A2D               rs / rt of the instruction in D
//   TuseRsD, TuseRtD       earliest use stage (0 = D, 1 = E, 3 = unused)
//   A1E, A2E, A3E          rs / rt / destination in E
//   A2M, A3M               rt / destination in M
//   A3W                    destination in W
//   Res_E, Res_M, Res_W    result class (0 ALU, 1 DM, 2 PC link, 3 no write)
//   md_startE, md_isdivE   mult/div in E this cycle, and whether it is a div
//   mdUseD                 instruction in D reads or writes HI/LO
//   excM, eretM            exception / eret at M (pipeline flush)
//   pc_en, ifid_en         write enables for PC and IF/ID
//   IFID_clr, IDEX_clr,
//   EXMEM_clr              synchronous clears for those pipeline registers
//   fwd_rsD, fwd_rtD,
//   fwd_rsE, fwd_rtE       0 regfile, 1 M ALU, 2 M PC+8, 3 W write data
//   fwd_rtM                0 pipeline value, 1 W write data
//   md_busy                mult/div counter non-zero (registered)
//
// Stall, clear and forward outputs are combinational; md_busy is a flop.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1D,
    input  logic [4:0] A2D,
    input  logic [1:0] TuseRsD,
    input  logic [1:0] TuseRtD,
    input  logic [4:0] A2E,
    input  logic [4:0] A3E,
    input  logic [4:0] A2M,
    input  logic [4:0] A3M,
    input  logic [4:0] A3W,
    input  logic [1:0] Res_E,
    input  logic [1:0] Res_M,
    input  logic [1:0] Res_W,
    input  logic [4:0] A1E,
    input  logic       md_startE,
    input  logic       md_isdivE,
    input  logic       mdUseD,
    input  logic       excM,
    input  logic       eretM,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       IFID_clr,
    output logic       IDEX_clr,
    output logic       EXMEM_clr,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM,
    output logic       md_busy
);

    // Result classes
    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_DM  = 2'd1;
    localparam logic [1:0] RES_PC  = 2'd2;
    localparam logic [1:0] RES_NW  = 2'd3;

    // Forward mux selects
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_M_ALU = 2'd1;
    localparam logic [1:0] FWD_M_PC  = 2'd2;
    localparam logic [1:0] FWD_W     = 2'd3;

    // Counter load values
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Cycles until a producer in E has its result available.
    function automatic logic [1:0] tnew_e(input logic [1:0] res);
        logic [1:0] t;
        case (res)
            RES_ALU: t = 2'd1;
            RES_DM:  t = 2'd2;
            RES_PC:  t = 2'd0;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    // Cycles until a producer in M has its result available.
    function automatic logic [1:0] tnew_m(input logic [1:0] res);
        logic [1:0] t;
        case (res)
            RES_ALU: t = 2'd0;
            RES_DM:  t = 2'd1;
            RES_PC:  t = 2'd0;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    // A stage only produces a value when it writes a real register.
    function automatic logic writes_reg(input logic [4:0] a3, input logic [1:0] res);
        return (a3 != 5'd0) && (res != RES_NW);
    endfunction

    // Operand src (used at stage tuse) needs a value not yet available.
    // A tuse of 3 (unused) is never below any Tnew, so it never stalls.
    function automatic logic data_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3e,
        input logic [1:0] rese,
        input logic [4:0] a3m,
        input logic [1:0] resm
    );
        logic hz;
        if (src == 5'd0) begin
            hz = 1'b0;
        end else begin
            hz = (writes_reg(a3e, rese) && (src == a3e) && (tuse < tnew_e(rese))) ||
                 (writes_reg(a3m, resm) && (src == a3m) && (tuse < tnew_m(resm)));
        end
        return hz;
    endfunction

    // Forward select for one operand. A matching producer in M shadows W even
    // when it cannot forward (DM): the W value would be stale, and the stall
    // logic or a later stage's forward picks up the loaded value.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] a3m,
        input logic [1:0] resm,
        input logic [4:0] a3w,
        input logic [1:0] resw
    );
        logic [1:0] sel;
        if (src == 5'd0) begin
            sel = FWD_RF;
        end else if (writes_reg(a3m, resm) && (src == a3m)) begin
            case (resm)
                RES_ALU: sel = FWD_M_ALU;
                RES_PC:  sel = FWD_M_PC;
                default: sel = FWD_RF;
            endcase
        end else if (writes_reg(a3w, resw) && (src == a3w)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic flush_s;
    logic data_stall_s;
    logic md_stall_s;
    logic stall_s;

    assign flush_s = excM | eretM;

    assign data_stall_s = data_hazard(A1D, TuseRsD, A3E, Res_E, A3M, Res_M) |
                          data_hazard(A2D, TuseRtD, A3E, Res_E, A3M, Res_M);

    assign stall_s = data_stall_s | md_stall_s;

    // -------------------------------------------------------------------------
    // Mult/div busy counter
    // -------------------------------------------------------------------------
`ifdef HAZARD_MD_EN
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       md_busy_q, md_busy_d;

    // Next-state logic: load on issue from IDLE, count down while BUSY.
    // A flush only blocks a new load; it never aborts a running operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_startE && !flush_s) begin
                    cnt_d   = md_isdivE ? DIV_LOAD : MULT_LOAD;
                    state_d = MD_BUSY;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = MD_IDLE;
            end
        endcase
        md_busy_d = (cnt_d != 4'd0);
    end

    // Counter state, count and registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= 4'd0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    assign md_busy    = md_busy_q;
    // The issuing instruction itself counts: a consumer right behind it waits.
    assign md_stall_s = mdUseD & (md_startE | md_busy_q);
`else
    logic unused_md_s;

    assign md_busy     = 1'b0;
    assign md_stall_s  = 1'b0;
    assign unused_md_s = ^{clk, md_startE, md_isdivE, mdUseD, MULT_LOAD, DIV_LOAD};
`endif

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------

    // Enables, clears and forward selects; flush takes priority over stall.
    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        IFID_clr  = 1'b0;
        IDEX_clr  = 1'b0;
        EXMEM_clr = 1'b0;
        fwd_rsD   = FWD_RF;
        fwd_rtD   = FWD_RF;
        fwd_rsE   = FWD_RF;
        fwd_rtE   = FWD_RF;
        fwd_rtM   = 1'b0;
        if (reset) begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            IFID_clr  = 1'b0;
            IDEX_clr  = 1'b0;
            EXMEM_clr = 1'b0;
        end else begin
            fwd_rsD = fwd_sel(A1D, A3M, Res_M, A3W, Res_W);
            fwd_rtD = fwd_sel(A2D, A3M, Res_M, A3W, Res_W);
            fwd_rsE = fwd_sel(A1E, A3M, Res_M, A3W, Res_W);
            fwd_rtE = fwd_sel(A2E, A3M, Res_M, A3W, Res_W);
            fwd_rtM = writes_reg(A3W, Res_W) && (A2M == A3W);
            if (flush_s) begin
                pc_en     = 1'b1;
                ifid_en   = 1'b1;
                IFID_clr  = 1'b1;
                IDEX_clr  = 1'b1;
                EXMEM_clr = 1'b1;
            end else if (stall_s) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                IFID_clr  = 1'b0;
                IDEX_clr  = 1'b1;
                EXMEM_clr = 1'b0;
            end else begin
                pc_en     = 1'b1;
                ifid_en   = 1'b1;
                IFID_clr  = 1'b0;
                IDEX_clr  = 1'b0;
                EXMEM_clr = 1'b0;
            end
        end
    end

endmodule
